// File: rtl/life_arena.sv
// Game of Life arena: double-banked cell store with a one-cell-per-cycle B3/S23 generation engine.
// Latency: reads 1 cycle; a generation takes W*H+1 cycles from step to gen_done.
// Backpressure: none; step and seed writes are dropped while busy, and reads are never stalled.
module life_arena #(
   parameter int ARENA_WIDTH  = 10,
   parameter int ARENA_HEIGHT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  arena_row_select,
   input  logic [7:0]  arena_column_select,
   output logic        arena_cell_value,
   input  logic        step,
   input  logic        wr_en,
   input  logic [7:0]  wr_row,
   input  logic [7:0]  wr_col,
   input  logic        wr_value,
   output logic        busy,
   output logic        gen_done,
   output logic [15:0] generation
);

   localparam int RW = $clog2(ARENA_HEIGHT);
   localparam int CW = $clog2(ARENA_WIDTH);
   localparam logic [RW-1:0] R_LAST = RW'(ARENA_HEIGHT - 1);
   localparam logic [CW-1:0] C_LAST = CW'(ARENA_WIDTH - 1);
   localparam logic [7:0]    H8     = 8'(ARENA_HEIGHT);
   localparam logic [7:0]    W8     = 8'(ARENA_WIDTH);

   typedef logic [ARENA_HEIGHT-1:0][ARENA_WIDTH-1:0] grid_t;
   typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;

   grid_t         bank_q [2];
   grid_t         bank_d [2];
   grid_t         front;
   state_t        state_q, state_d;
   logic          fsel_q, fsel_d;
   logic [RW-1:0] r_q, r_d;
   logic [CW-1:0] c_q, c_d;
   logic          cell_q, cell_d;
   logic          done_q, done_d;
   logic [15:0]   gen_q, gen_d;

   logic [RW-1:0] rm, rp;
   logic [CW-1:0] cm, cp;
   logic [7:0]    nbr;
   logic [3:0]    cnt;
   logic          nxt;

   // The bank currently visible to the reader and used as the source of the scan.
   always_comb front = bank_q[fsel_q];

   // Toroidal neighbourhood of the scan cell and its B3/S23 successor.
   always_comb begin
      rm  = (r_q == '0)     ? R_LAST : r_q - RW'(1);
      rp  = (r_q == R_LAST) ? '0     : r_q + RW'(1);
      cm  = (c_q == '0)     ? C_LAST : c_q - CW'(1);
      cp  = (c_q == C_LAST) ? '0     : c_q + CW'(1);
      nbr = {front[rm][cm], front[rm][c_q], front[rm][cp],
             front[r_q][cm],                front[r_q][cp],
             front[rp][cm], front[rp][c_q], front[rp][cp]};
      cnt = '0;
      for (int i = 0; i < 8; i++) cnt = cnt + {3'b000, nbr[i]};
      nxt = (cnt == 4'd3) | (front[r_q][c_q] & (cnt == 4'd2));
   end

   // Sequencer: accept step in IDLE, walk cells row-major, then swap banks and count.
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      fsel_d  = fsel_q;
      done_d  = 1'b0;
      gen_d   = gen_q;
      case (state_q)
         IDLE: begin
            if (step) begin
               state_d = SCAN;
               r_d     = '0;
               c_d     = '0;
            end
         end
         SCAN: begin
            if (c_q == C_LAST) begin
               c_d = '0;
               if (r_q == R_LAST) state_d = SWAP;
               else               r_d     = r_q + RW'(1);
            end else begin
               c_d = c_q + CW'(1);
            end
         end
         SWAP: begin
            fsel_d  = ~fsel_q;
            done_d  = 1'b1;
            gen_d   = gen_q + 16'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bank updates: seed writes land in the front bank only when idle; the scan fills the back bank.
   always_comb begin
      bank_d[0] = bank_q[0];
      bank_d[1] = bank_q[1];
      if (state_q == IDLE && wr_en && wr_row < H8 && wr_col < W8)
         bank_d[fsel_q][wr_row[RW-1:0]][wr_col[CW-1:0]] = wr_value;
      if (state_q == SCAN)
         bank_d[~fsel_q][r_q][c_q] = nxt;
   end

   // Read port: out-of-range indices read as dead.
   always_comb begin
      cell_d = 1'b0;
      if (arena_row_select < H8 && arena_column_select < W8)
         cell_d = front[arena_row_select[RW-1:0]][arena_column_select[CW-1:0]];
   end

   // State registers; reset clears both banks and abandons any generation in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bank_q[0] <= '0;
         bank_q[1] <= '0;
         state_q   <= IDLE;
         fsel_q    <= 1'b0;
         r_q       <= '0;
         c_q       <= '0;
         cell_q    <= 1'b0;
         done_q    <= 1'b0;
         gen_q     <= '0;
      end else begin
         bank_q[0] <= bank_d[0];
         bank_q[1] <= bank_d[1];
         state_q   <= state_d;
         fsel_q    <= fsel_d;
         r_q       <= r_d;
         c_q       <= c_d;
         cell_q    <= cell_d;
         done_q    <= done_d;
         gen_q     <= gen_d;
      end
   end

   assign arena_cell_value = cell_q;
   assign busy             = (state_q != IDLE);
   assign gen_done         = done_q;
   assign generation       = gen_q;

endmodule

// File: tb/tb_life_arena.sv
// Self-checking bench for life_arena: read tables, hand sequences for timing corners, random patterns.
// Latency: checks read latency 1 and generation latency W*H+1 against a grid-level model.
// Backpressure: verifies step/write lockout while busy and reset abort mid-scan.
module tb_life_arena;
   localparam int W = 10;
   localparam int H = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  arena_row_select, arena_column_select;
   logic        arena_cell_value;
   logic        step, wr_en, wr_value;
   logic [7:0]  wr_row, wr_col;
   logic        busy, gen_done;
   logic [15:0] generation;

   life_arena #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
      .clk(clk), .reset(reset),
      .arena_row_select(arena_row_select), .arena_column_select(arena_column_select),
      .arena_cell_value(arena_cell_value),
      .step(step), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_value(wr_value),
      .busy(busy), .gen_done(gen_done), .generation(generation)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int miss = 0;
   int model [H][W];
   int gen_m = 0;

   typedef struct { int phase; int r; int c; int exp; } rd_vec_t;
   rd_vec_t tbl [18];

   task automatic chk(input string name, input int got, input int exp);
      vecs++;
      if (got != exp) begin
         miss++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int r, input int c, output int v);
      arena_row_select    = 8'(r);
      arena_column_select = 8'(c);
      tick();
      v = int'(arena_cell_value);
   endtask

   task automatic chk_grid(input string name);
      int v;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            rd(r, c, v);
            chk($sformatf("%s(%0d,%0d)", name, r, c), v, model[r][c]);
         end
      rd(12, 3, v);  chk({name, "_oor_row"}, v, 0);
      rd(3, 200, v); chk({name, "_oor_col"}, v, 0);
   endtask

   task automatic seed(input int r, input int c, input int v);
      wr_en = 1'b1; wr_row = 8'(r); wr_col = 8'(c); wr_value = v[0];
      tick();
      wr_en = 1'b0;
      if (r < H && c < W) model[r][c] = v;
   endtask

   function automatic void model_clear();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) model[r][c] = 0;
   endfunction

   // Next generation from the rules: count the 8 neighbours on a torus.
   function automatic void model_step();
      int nx [H][W];
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            int n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0) n += model[(r + dr + H) % H][(c + dc + W) % W];
            nx[r][c] = (n == 3 || (model[r][c] == 1 && n == 2)) ? 1 : 0;
         end
      model = nx;
      gen_m = (gen_m + 1) % 65536;
   endfunction

   task automatic run_step(input string name, input bit inject);
      int busy_cnt = 0;
      int done_cnt = 0;
      int t = 0;
      step = 1'b1;
      tick();
      step = 1'b0;
      while (!gen_done && t < 400) begin
         if (busy) busy_cnt++;
         if (inject && t == 10) begin
            wr_en = 1'b1; wr_row = 8'd7; wr_col = 8'd7; wr_value = 1'b1; step = 1'b1;
         end else if (inject && t == 11) begin
            wr_en = 1'b0; step = 1'b0;
         end
         tick();
         t++;
      end
      chk({name, "_gen_done_seen"}, int'(gen_done), 1);
      chk({name, "_busy_at_done"}, int'(busy), 0);
      chk({name, "_busy_cycles"}, busy_cnt, W * H + 1);
      if (gen_done) done_cnt++;
      if (inject) begin
         for (int i = 0; i < 150; i++) begin
            tick();
            if (gen_done) done_cnt++;
         end
         chk({name, "_done_pulses"}, done_cnt, 1);
      end
      model_step();
      chk({name, "_generation"}, int'(generation), gen_m);
   endtask

   initial begin
      int v;
      reset = 1'b1; step = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_value = 1'b0;
      arena_row_select = '0; arena_column_select = '0;
      model_clear();

      tbl[0]  = '{0, 4, 3, 1};  tbl[1]  = '{0, 4, 4, 1};  tbl[2]  = '{0, 4, 5, 1};
      tbl[3]  = '{0, 3, 4, 0};  tbl[4]  = '{0, 5, 4, 0};  tbl[5]  = '{0, 4, 2, 0};
      tbl[6]  = '{0, 4, 6, 0};  tbl[7]  = '{0, 12, 3, 0}; tbl[8]  = '{0, 4, 10, 0};
      tbl[9]  = '{1, 3, 4, 1};  tbl[10] = '{1, 4, 4, 1};  tbl[11] = '{1, 5, 4, 1};
      tbl[12] = '{1, 4, 3, 0};  tbl[13] = '{1, 4, 5, 0};  tbl[14] = '{1, 2, 4, 0};
      tbl[15] = '{1, 6, 4, 0};  tbl[16] = '{1, 12, 3, 0}; tbl[17] = '{1, 255, 255, 0};

      // Reset state
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_cell", int'(arena_cell_value), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_gen_done", int'(gen_done), 0);
      chk("rst_generation", int'(generation), 0);
      chk_grid("rst");

      // Blinker seed, read table for the horizontal phase
      seed(4, 3, 1); seed(4, 4, 1); seed(4, 5, 1);
      for (int i = 0; i < 18; i++)
         if (tbl[i].phase == 0) begin
            rd(tbl[i].r, tbl[i].c, v);
            chk($sformatf("tbl0_%0d", i), v, tbl[i].exp);
         end

      // Read consistency through the first blinker generation, cycle by cycle
      arena_row_select = 8'd4; arena_column_select = 8'd3;
      step = 1'b1;
      tick();
      step = 1'b0;
      for (int j = 1; j <= W * H + 3; j++) begin
         tick();
         chk($sformatf("cons_read_%0d", j), int'(arena_cell_value), (j <= W * H + 1) ? 1 : 0);
         chk($sformatf("cons_done_%0d", j), int'(gen_done), (j == W * H + 1) ? 1 : 0);
         chk($sformatf("cons_busy_%0d", j), int'(busy), (j <= W * H) ? 1 : 0);
      end
      model_step();
      chk("blink1_generation", int'(generation), 1);
      for (int i = 0; i < 18; i++)
         if (tbl[i].phase == 1) begin
            rd(tbl[i].r, tbl[i].c, v);
            chk($sformatf("tbl1_%0d", i), v, tbl[i].exp);
         end
      chk_grid("blink1");

      // Second generation back to horizontal
      run_step("blink2", 1'b0);
      chk("blink2_gen_is_2", int'(generation), 2);
      chk_grid("blink2");

      // Lockout: write and step during SCAN must be ignored
      run_step("lock", 1'b1);
      chk_grid("lock");

      // Toroidal wrap
      reset = 1'b1; tick(); reset = 1'b0;
      model_clear(); gen_m = 0;
      seed(0, 9, 1); seed(0, 0, 1); seed(0, 1, 1);
      run_step("wrap", 1'b0);
      chk_grid("wrap");

      // Random patterns, including out-of-range seed writes
      for (int it = 0; it < 3; it++) begin
         for (int k = 0; k < 40; k++)
            seed(int'($urandom_range(0, 11)), int'($urandom_range(0, 11)), int'($urandom_range(0, 1)));
         run_step($sformatf("rnd%0d_a", it), 1'b0);
         chk_grid($sformatf("rnd%0d_a", it));
         run_step($sformatf("rnd%0d_b", it), 1'b0);
         chk_grid($sformatf("rnd%0d_b", it));
      end

      // Reset 40 cycles into a scan
      step = 1'b1; tick(); step = 1'b0;
      for (int i = 0; i < 40; i++) tick();
      reset = 1'b1;
      #1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_generation", int'(generation), 0);
      tick();
      reset = 1'b0;
      model_clear(); gen_m = 0;
      begin
         int pulses = 0;
         for (int i = 0; i < 200; i++) begin
            tick();
            if (gen_done) pulses++;
         end
         chk("midrst_no_done", pulses, 0);
      end
      chk("midrst_busy_after", int'(busy), 0);
      chk("midrst_generation_after", int'(generation), 0);
      chk_grid("midrst");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule

// File: doc/life_arena.md
# life_arena

Cell-state store and generation engine for the Game of Life arena. Holds an ARENA_WIDTH x ARENA_HEIGHT grid of one-bit cells in two register banks: a front bank and a back bank. It serves single-cell reads from the VGA image generator, which selects a row and column and samples the cell value. On request it computes the next generation under the B3/S23 rules with toroidal wrap-around, then swaps the two banks. A seed write port lets the controller load patterns between generations.

## Interface
- ARENA_WIDTH, 10, number of columns; legal range 3..64.
- ARENA_HEIGHT, 10, number of rows; legal range 3..64.

- clk  in  1  single clock; shared with the VGA pixel clock, which drives arena_clk.
- reset  in  1  asynchronous, active-high reset.
- arena_row_select  in  8  read row index.
- arena_column_select  in  8  read column index.
- arena_cell_value  out  1  registered cell state at the selected row/column of the front bank.
- step  in  1  request one generation; sampled on each clk edge.
- wr_en  in  1  seed write strobe.
- wr_row  in  8  seed write row.
- wr_col  in  8  seed write column.
- wr_value  in  1  cell state to write (1 = alive).
- busy  out  1  high while a generation is in progress.
- gen_done  out  1  one-cycle pulse when the new generation becomes the front bank.
- generation  out  16  count of completed generations; wraps from 0xFFFF to 0x0000.

## Operation
- Reset: both banks are all dead; front select = bank 0; state IDLE.
- Reset output values: arena_cell_value=0, busy=0, gen_done=0, generation=0.
- Read port:
  - Each edge registers front[row][col] into arena_cell_value.
  - Any index >= ARENA_HEIGHT / ARENA_WIDTH registers 0.
  - Reads are never stalled and always return front-bank data, including during SCAN.
- Seed write:
  - Applied to the front bank at the edge only when state is IDLE and wr_row/wr_col are in range.
  - Ignored in SCAN or SWAP, or when out of range. There is no error flag.
- States: IDLE, SCAN, SWAP.
- IDLE:
  - step=1 -> SCAN; cell index (r,c) is set to (0,0); busy=1.
  - A write in the same cycle as step is committed before the scan begins, so the scan sees it.
- SCAN:
  - One cell per edge, in row-major order (c increments first, then r).
  - Neighbour count is the sum of the 8 surrounding front-bank cells, with indices taken modulo width/height (toroidal). The count uses 4 bits, range 0..8.
  - next = (count==3) | (alive & count==2); this is written to back[r][c].
  - After cell (ARENA_HEIGHT-1, ARENA_WIDTH-1) -> SWAP.
- SWAP:
  - Toggles front select.
  - gen_done=1 for exactly this cycle; generation increments by 1.
  - busy=0; -> IDLE.
- step while busy is ignored; it is not queued.
- Reset mid-SCAN or mid-SWAP:
  - Immediate return to the reset state; both banks are cleared.
  - No gen_done pulse and no generation increment.

## Timing
- Read latency is 1 cycle: an index presented before edge k appears on arena_cell_value after edge k.
- Generation latency, with step accepted at edge k:
  - busy=1 after edge k.
  - SCAN occupies edges k+1 .. k+W*H.
  - SWAP is executed at edge k+W*H+1: gen_done=1 and busy=0 from that edge for one cycle.
  - Total busy time is W*H+1 cycles (101 cycles for a 10x10 arena).
- Reads sampled at or before edge k+W*H+1 return the old generation. Reads sampled from edge k+W*H+2 onward return the new generation.
- A new step can be accepted in the cycle gen_done is high (the state is already IDLE), giving back-to-back generations every W*H+2 cycles.

## Test plan
- Reset → all outputs 0; reading every (r,c) in 10x10 returns 0; reading (12,3) returns 0.
- Blinker:
  - Stimulus: seed (4,3),(4,4),(4,5); step.
  - After gen_done: live cells exactly (3,4),(4,4),(5,4); generation=1.
  - After a second step: horizontal again; generation=2.
- Wrap-around:
  - Stimulus: seed (0,9),(0,0),(0,1); step.
  - Response: live cells exactly (9,0),(0,0),(1,0); all others dead.
- Lockout:
  - Stimulus: during SCAN, write (7,7)=1 and pulse step.
  - Response: (7,7) stays dead; only one gen_done occurs; busy spans exactly 101 cycles.
- Read consistency:
  - Stimulus: continuous reads of (4,3) throughout a blinker step.
  - Response: reads return 1 up to and including the sample at the SWAP edge, and 0 afterwards.
- Reset mid-SCAN:
  - Stimulus: assert reset 40 cycles after step.
  - Response: busy=0, gen_done never pulses, generation=0, all cells read 0.
